pipeline_ctrl: RTL and testbench

Stall/flush sequencer for the five-stage core. It drives `inst_enable` of `inst_decode` (the IF/ID register) and the enables and bubbles of the PC and ID/EX registers. It resolves load-use hazards, flushes wrong-path instructions on taken branches, and freezes the pipeline while a multi-cycle FPU operation or a UART transfer occupies EX.

---
 rtl/ctrl_pkg.sv | 14 +
 rtl/hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// The state enum is shared with anything that needs to decode the sequencer state.
package ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FPU_WAIT  = 2'd1,
        UART_WAIT = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] NOP_INST = 32'h0;
    localparam logic [4:0]  ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparison between the load in EX and the sources decoded in ID.
// Kept standalone so the same register compare can serve forwarding later.
module hazard_detect
    import ctrl_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_valid_i,
    input  logic       ex_MemRead_i,
    input  logic       ex_RegWrite_i,
    input  logic [4:0] ex_rd_i,
    output logic       lu_o
);

    logic rd_match;

    // r0 is hard-wired to zero, so a load targeting it never creates a dependency
    assign rd_match = (ex_rd_i != ZERO_REG) &&
                      ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

    assign lu_o = id_valid_i & ex_valid_i & ex_MemRead_i & ex_RegWrite_i & rd_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: drives PC, IF/ID and ID/EX enables/bubbles, and
// freezes EX while a multi-cycle FPU op or a UART transfer is in flight.
module pipeline_ctrl
    import ctrl_pkg::*;
#(
    parameter int FPU_LATENCY = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 ex_valid,
    input  logic                 ex_MemRead,
    input  logic                 ex_RegWrite,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_fpu_multi,
    input  logic                 ex_uart,
    input  logic                 branch_taken,
    input  logic                 uart_ack,
    output logic                 pc_enable,
    output logic                 inst_enable,
    output logic                 if_flush,
    output logic                 id_bubble,
    output logic                 ex_hold,
    output logic                 uart_req,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int CW = $clog2(FPU_LATENCY + 1);

    ctrl_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_count_q;
    logic                 lu;

    hazard_detect u_hazard (
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .ex_valid_i    (ex_valid),
        .ex_MemRead_i  (ex_MemRead),
        .ex_RegWrite_i (ex_RegWrite),
        .ex_rd_i       (ex_rd),
        .lu_o          (lu)
    );

    always_comb begin
        pc_enable   = 1'b1;
        inst_enable = 1'b1;
        if_flush    = 1'b0;
        id_bubble   = 1'b0;
        ex_hold     = 1'b0;
        uart_req    = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (reset) begin
            pc_enable   = 1'b0;
            inst_enable = 1'b0;
            id_bubble   = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    // Branch outranks everything: the ID instruction is wrong-path anyway
                    if (branch_taken) begin
                        if_flush  = 1'b1;
                        id_bubble = 1'b1;
                    end else if (ex_valid && ex_fpu_multi && (FPU_LATENCY > 1)) begin
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        ex_hold     = 1'b1;
                        state_d     = FPU_WAIT;
                        cnt_d       = CW'(FPU_LATENCY - 2);
                    end else if (ex_valid && ex_uart) begin
                        uart_req = 1'b1;
                        if (!uart_ack) begin
                            pc_enable   = 1'b0;
                            inst_enable = 1'b0;
                            ex_hold     = 1'b1;
                            state_d     = UART_WAIT;
                        end
                    end else if (lu) begin
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        id_bubble   = 1'b1;
                    end
                end
                FPU_WAIT: begin
                    if (cnt_q != '0) begin
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        ex_hold     = 1'b1;
                        cnt_d       = cnt_q - 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                UART_WAIT: begin
                    uart_req = 1'b1;
                    if (uart_ack) begin
                        state_d = RUN;
                    end else begin
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        ex_hold     = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_enable) stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second instance with FPU_LATENCY=1
// covers the no-hold FPU case.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic        id_valid, ex_valid, ex_MemRead, ex_RegWrite;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        ex_fpu_multi, ex_uart, branch_taken, uart_ack;
    logic        pc_enable, inst_enable, if_flush, id_bubble, ex_hold, uart_req;
    logic        pc1, inst1, flush1, bubble1, hold1, req1;
    logic [31:0] stall_count, stall_count1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.FPU_LATENCY(3), .CNT_WIDTH(32)) dut (
        .CLK(CLK), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
        .ex_rd(ex_rd), .ex_fpu_multi(ex_fpu_multi), .ex_uart(ex_uart),
        .branch_taken(branch_taken), .uart_ack(uart_ack),
        .pc_enable(pc_enable), .inst_enable(inst_enable), .if_flush(if_flush),
        .id_bubble(id_bubble), .ex_hold(ex_hold), .uart_req(uart_req),
        .stall_count(stall_count)
    );

    pipeline_ctrl #(.FPU_LATENCY(1), .CNT_WIDTH(32)) dut1 (
        .CLK(CLK), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
        .ex_rd(ex_rd), .ex_fpu_multi(ex_fpu_multi), .ex_uart(ex_uart),
        .branch_taken(branch_taken), .uart_ack(uart_ack),
        .pc_enable(pc1), .inst_enable(inst1), .if_flush(flush1),
        .id_bubble(bubble1), .ex_hold(hold1), .uart_req(req1),
        .stall_count(stall_count1)
    );

    // Output vector order: {pc_enable, inst_enable, if_flush, id_bubble, ex_hold, uart_req}
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, pc_enable, inst_enable, if_flush, id_bubble, ex_hold, uart_req},
            {26'd0, exp});
    endtask

    // Inputs change 1 time unit after posedge; outputs sampled mid-cycle
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs = 0; id_rt = 0;
        ex_valid = 0; ex_MemRead = 0; ex_RegWrite = 0; ex_rd = 0;
        ex_fpu_multi = 0; ex_uart = 0; branch_taken = 0; uart_ack = 0;
    endtask

    initial begin
        clear_in();
        reset = 1;
        #4;
        chk_out("reset_outs", 6'b000100);
        next_cycle();
        next_cycle();
        reset = 0;
        #4;
        chk_out("post_reset_run", 6'b110000);
        chk("post_reset_cnt", stall_count, 32'd0);

        // Load-use on rs: one stall cycle then normal
        next_cycle();
        id_valid = 1; id_rs = 5; id_rt = 9;
        ex_valid = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_rd = 5;
        #4 chk_out("lu_rs_stall", 6'b000100);
        next_cycle();
        ex_valid = 0; ex_MemRead = 0; ex_RegWrite = 0; ex_rd = 0;
        #4 chk_out("lu_rs_after", 6'b110000);
        chk("lu_rs_cnt", stall_count, 32'd1);

        // Load to r0 never stalls
        next_cycle();
        id_rs = 0; id_rt = 0; ex_valid = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_rd = 0;
        #4 chk_out("lu_r0_nostall", 6'b110000);

        // Load-use on rt
        next_cycle();
        id_rs = 3; id_rt = 7; ex_rd = 7;
        #4 chk_out("lu_rt_stall", 6'b000100);

        // Branch with simultaneous load-use: flush wins, no stall
        next_cycle();
        branch_taken = 1;
        #4 chk_out("branch_lu_flush", 6'b111100);
        chk("branch_cnt", stall_count, 32'd2);

        // FPU op, latency 3: two hold cycles, release on the third
        next_cycle();
        clear_in();
        ex_valid = 1; ex_fpu_multi = 1;
        #4 chk_out("fpu_hold0", 6'b000010);
        chk("fpu_lat1_nohold", {26'd0, pc1, inst1, flush1, bubble1, hold1, req1}, 32'b110000);
        next_cycle();
        #4 chk_out("fpu_hold1", 6'b000010);
        next_cycle();
        #4 chk_out("fpu_release", 6'b110000);
        next_cycle();
        clear_in();
        #4 chk("fpu_cnt", stall_count, 32'd4);

        // UART with ack four cycles after the request
        ex_valid = 1; ex_uart = 1;
        #4 chk_out("uart_req0", 6'b000011);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            #4 chk_out($sformatf("uart_wait%0d", i), 6'b000011);
        end
        next_cycle();
        uart_ack = 1;
        #4 chk_out("uart_ack_release", 6'b110001);
        next_cycle();
        clear_in();
        #4 chk_out("uart_done", 6'b110000);
        chk("uart_cnt", stall_count, 32'd8);

        // Ack in the request cycle: no hold at all
        next_cycle();
        ex_valid = 1; ex_uart = 1; uart_ack = 1;
        #4 chk_out("uart_same_cycle", 6'b110001);
        next_cycle();
        clear_in();
        uart_ack = 1;
        #4 chk_out("stray_ack_ignored", 6'b110000);
        chk("uart_fast_cnt", stall_count, 32'd8);

        // Reset while waiting on the UART aborts the wait
        next_cycle();
        clear_in();
        ex_valid = 1; ex_uart = 1;
        next_cycle();
        #4 chk_out("uart_wait_pre_reset", 6'b000011);
        reset = 1;
        #1 chk_out("uart_reset_outs", 6'b000100);
        next_cycle();
        reset = 0;
        clear_in();
        #4 chk_out("after_reset_run", 6'b110000);
        chk("after_reset_cnt", stall_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
